vote_tally_auth: RTL and testbench
==================================

# vote_tally_auth

Downstream consumer of the voter-enrollment stage. Latches the three enrolled 128-bit encrypted credentials once, then accepts ballots (encrypted credential + candidate) over a valid/ready handshake. Each ballot is authenticated against the enrolled set, checked for double voting, and tallied. A per-ballot response code is returned. Sits between the enrollment/crypto stages and the result-reporting logic.

## Interface
- CNT_W, 8, width of each candidate tally counter (saturating)
- MAX_FAIL, 3, number of unknown-credential ballots (cumulative) after which the block locks; range 1..15

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enroll_load  in  1  one-cycle strobe: capture enrolled_1..3
- enrolled_1  in  128  enrolled encrypted credential, voter 1
- enrolled_2  in  128  enrolled encrypted credential, voter 2
- enrolled_3  in  128  enrolled encrypted credential, voter 3
- close_poll  in  1  strobe: close the poll (sticky)
- vote_valid  in  1  ballot present
- vote_ready  out  1  block can accept a ballot
- vote_cred  in  128  submitted encrypted credential
- vote_cand  in  2  candidate index 0..3
- resp_valid  out  1  one-cycle response strobe
- resp_code  out  2  00 accepted, 01 unknown credential, 10 already voted, 11 rejected (poll closed or locked)
- tally_0..tally_3  out  CNT_W each  per-candidate vote counts
- voted_mask  out  3  bit i set once voter i+1 has cast an accepted vote
- enrolled  out  1  credentials captured
- closed  out  1  poll closed
- locked  out  1  failure limit reached

## Operation
- Reset clears all outputs, state, credential registers, and the fail counter. Each tally_* = 0, voted_mask = 0, resp_code = 00, and every 1-bit output = 0. FSM enters IDLE.
- Enrollment:
  - enroll_load while enrolled=0 and FSM in IDLE: capture enrolled_1..3 and set enrolled=1.
  - Any later enroll_load is ignored; credentials are frozen until rst.
- closed is set on any cycle close_poll=1 and stays set until rst.
- FSM states: IDLE, CHECK, COMMIT, RESP.
  - IDLE: vote_ready = enrolled. If vote_valid & vote_ready, register vote_cred/vote_cand and go to CHECK.
  - CHECK: compute the code from the registered ballot, in this priority:
    - closed|locked -> 11.
    - No exact 128-bit match with any enrolled credential -> 01.
    - Matched voter already set in voted_mask -> 10.
    - Otherwise -> 00.
    - If several enrolled credentials are identical, the lowest index wins.
    - Go to COMMIT.
  - COMMIT:
    - Code 00: set the voted_mask bit; increment tally_<cand>, saturating at 2^CNT_W-1 (no wrap).
    - Code 01: increment the fail counter; if it reaches MAX_FAIL, set locked (sticky until rst).
    - Codes 10/11: no state update.
    - Go to RESP.
  - RESP: resp_valid=1 and resp_code driven. Go to IDLE.
- vote_ready=0 in CHECK, COMMIT, RESP. The fail counter is never cleared by an accepted vote.
- close_poll arriving during CHECK does not affect a ballot already past CHECK.

## Timing
- Ballot handshake in cycle T. CHECK at T+1, COMMIT at T+2.
- resp_valid high exactly in cycle T+3.
- vote_ready high again at T+4. Maximum throughput is one ballot per 4 cycles.
- tally_*, voted_mask, and locked change on the clock edge ending COMMIT, so they are visible in the same cycle as resp_valid.
- resp_code holds its last value after resp_valid drops.
- enroll_load in the handshake cycle of the first ballot is impossible: vote_ready=0 until enrolled=1, which is visible the cycle after the strobe.
- rst mid-ballot (any state): the ballot is discarded and no resp_valid is issued. All outputs are at reset values on the following cycle.
- vote_valid may stay high across responses. A new ballot is taken only in IDLE.

## Test plan
- Enroll credentials A,B,C; ballot (A,cand 2) -> resp_valid at T+3 with code 00, tally_2=1, voted_mask=001, vote_ready high at T+4.
- Second ballot (A,cand 1) -> code 10, tally_1=0, tally_2 unchanged at 1.
- Three ballots with unknown credential X (MAX_FAIL=3) -> codes 01,01,01; locked=1 after the third. Then ballot (B,cand 0) -> code 11, tally_0=0.
- Pulse close_poll, then ballot (C,cand 3) -> code 11, closed=1, voted_mask unchanged.
- CNT_W=2, with voters reused across resets kept out of the count check: preload via 3 accepted votes to cand 0 plus forced saturation -> tally_0 stops at 3, no wrap.
- rst asserted in COMMIT -> no resp_valid, tally_* = 0, enrolled=0, vote_ready=0. A subsequent enroll_load re-captures new values.

Source files
------------

// File: rtl/vote_tally_auth.sv
`default_nettype none
// ============================================================================
//  Module      : vote_tally_auth
//  Description : Ballot authentication and tally block. Latches three
//                enrolled encrypted credentials once, then takes ballots over
//                a valid/ready handshake, authenticates each one against the
//                enrolled set, rejects double votes and accumulates saturating
//                per-candidate tallies. One response code is returned per
//                ballot, three cycles after the handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module vote_tally_auth #(
    parameter int CNT_W    = 8,
    parameter int MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enroll_load,
    input  logic [127:0]     enrolled_1,
    input  logic [127:0]     enrolled_2,
    input  logic [127:0]     enrolled_3,
    input  logic             close_poll,
    input  logic             vote_valid,
    output logic             vote_ready,
    input  logic [127:0]     vote_cred,
    input  logic [1:0]       vote_cand,
    output logic             resp_valid,
    output logic [1:0]       resp_code,
    output logic [CNT_W-1:0] tally_0,
    output logic [CNT_W-1:0] tally_1,
    output logic [CNT_W-1:0] tally_2,
    output logic [CNT_W-1:0] tally_3,
    output logic [2:0]       voted_mask,
    output logic             enrolled,
    output logic             closed,
    output logic             locked
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        COMMIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0] c_code_ok      = 2'b00;
    localparam logic [1:0] c_code_unknown = 2'b01;
    localparam logic [1:0] c_code_dup     = 2'b10;
    localparam logic [1:0] c_code_reject  = 2'b11;

    // Fail counter is 4 bits wide, enough for the 1..15 lock threshold.
    localparam logic [4:0] c_fail_limit = 5'(MAX_FAIL);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_t             state_q, state_d;

    logic               enrolled_q;
    logic [127:0]       cred1_q, cred2_q, cred3_q;
    logic               closed_q;
    logic               locked_q;
    logic [3:0]         fail_q;
    logic [2:0]         voted_q;
    logic [CNT_W-1:0]   tally_q [4];

    logic [127:0]       ballot_cred_q;
    logic [1:0]         ballot_cand_q;
    logic [1:0]         code_q, code_d;
    logic [2:0]         voter_q, voter_d;     // one-hot matched voter

    logic               w_take;
    logic [2:0]         w_match;
    logic [2:0]         w_hit;
    logic               w_already;
    logic               w_enroll;
    logic [4:0]         w_fail_next;

    // Raw 128-bit credential comparisons against the enrolled set.
    assign w_match = {ballot_cred_q == cred3_q,
                      ballot_cred_q == cred2_q,
                      ballot_cred_q == cred1_q};

    // Duplicate enrolled credentials resolve to the lowest voter index.
    assign w_hit = {w_match[2] & ~w_match[1] & ~w_match[0],
                    w_match[1] & ~w_match[0],
                    w_match[0]};

    assign w_already   = |(w_hit & voted_q);
    assign w_enroll    = enroll_load && !enrolled_q && (state_q == IDLE);
    assign w_fail_next = {1'b0, fail_q} + 5'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, handshake/response strobes and ballot classification.
    always_comb begin
        state_d    = state_q;
        vote_ready = 1'b0;
        resp_valid = 1'b0;
        w_take     = 1'b0;
        code_d     = code_q;
        voter_d    = voter_q;
        case (state_q)
            IDLE: begin
                vote_ready = enrolled_q;
                if (vote_valid && enrolled_q) begin
                    w_take  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                voter_d = w_hit;
                if (closed_q || locked_q) begin
                    code_d = c_code_reject;
                end else if (w_match == 3'b000) begin
                    code_d = c_code_unknown;
                end else if (w_already) begin
                    code_d = c_code_dup;
                end else begin
                    code_d = c_code_ok;
                end
                state_d = COMMIT;
            end
            COMMIT: begin
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Enrollment capture, poll close, ballot latch and commit-time updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            enrolled_q    <= 1'b0;
            cred1_q       <= '0;
            cred2_q       <= '0;
            cred3_q       <= '0;
            closed_q      <= 1'b0;
            locked_q      <= 1'b0;
            fail_q        <= '0;
            voted_q       <= '0;
            ballot_cred_q <= '0;
            ballot_cand_q <= '0;
            code_q        <= c_code_ok;
            voter_q       <= '0;
            for (int i = 0; i < 4; i++) begin
                tally_q[i] <= '0;
            end
        end else begin
            closed_q <= closed_q | close_poll;
            code_q   <= code_d;
            voter_q  <= voter_d;

            // Credentials are frozen after the first capture until reset.
            if (w_enroll) begin
                cred1_q    <= enrolled_1;
                cred2_q    <= enrolled_2;
                cred3_q    <= enrolled_3;
                enrolled_q <= 1'b1;
            end

            if (w_take) begin
                ballot_cred_q <= vote_cred;
                ballot_cand_q <= vote_cand;
            end

            if (state_q == COMMIT) begin
                case (code_q)
                    c_code_ok: begin
                        voted_q <= voted_q | voter_q;
                        if (tally_q[ballot_cand_q] != c_cnt_max) begin
                            tally_q[ballot_cand_q] <= tally_q[ballot_cand_q] + c_cnt_one;
                        end
                    end
                    c_code_unknown: begin
                        // Once locked, later ballots classify as rejected, so
                        // the counter cannot run past the limit.
                        if (fail_q != 4'hF) begin
                            fail_q <= w_fail_next[3:0];
                        end
                        if (w_fail_next >= c_fail_limit) begin
                            locked_q <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign resp_code  = code_q;
    assign tally_0    = tally_q[0];
    assign tally_1    = tally_q[1];
    assign tally_2    = tally_q[2];
    assign tally_3    = tally_q[3];
    assign voted_mask = voted_q;
    assign enrolled   = enrolled_q;
    assign closed     = closed_q;
    assign locked     = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_vote_tally_auth.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vote_tally_auth
//  Description : Self-checking bench for vote_tally_auth. Two instances share
//                all stimulus: A (CNT_W=2, MAX_FAIL=3) and B (CNT_W=1,
//                MAX_FAIL=1), so B shows tally saturation and an early lock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vote_tally_auth;

    localparam int CW_A = 2;
    localparam int MF_A = 3;
    localparam int CW_B = 1;
    localparam int MF_B = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enroll_load = 1'b0;
    logic            close_poll = 1'b0;
    logic            vote_valid = 1'b0;
    logic [127:0]    enrolled_1 = '0;
    logic [127:0]    enrolled_2 = '0;
    logic [127:0]    enrolled_3 = '0;
    logic [127:0]    vote_cred = '0;
    logic [1:0]      vote_cand = '0;

    logic            a_ready, a_rv, a_en, a_cl, a_lk;
    logic [1:0]      a_code;
    logic [2:0]      a_mask;
    logic [CW_A-1:0] a_t [4];
    logic            b_ready, b_rv, b_en, b_cl, b_lk;
    logic [1:0]      b_code;
    logic [2:0]      b_mask;
    logic [CW_B-1:0] b_t [4];

    vote_tally_auth #(.CNT_W(CW_A), .MAX_FAIL(MF_A)) dut_a (
        .clk(clk), .rst(rst), .enroll_load(enroll_load),
        .enrolled_1(enrolled_1), .enrolled_2(enrolled_2), .enrolled_3(enrolled_3),
        .close_poll(close_poll), .vote_valid(vote_valid), .vote_ready(a_ready),
        .vote_cred(vote_cred), .vote_cand(vote_cand), .resp_valid(a_rv),
        .resp_code(a_code), .tally_0(a_t[0]), .tally_1(a_t[1]), .tally_2(a_t[2]),
        .tally_3(a_t[3]), .voted_mask(a_mask), .enrolled(a_en), .closed(a_cl),
        .locked(a_lk)
    );

    vote_tally_auth #(.CNT_W(CW_B), .MAX_FAIL(MF_B)) dut_b (
        .clk(clk), .rst(rst), .enroll_load(enroll_load),
        .enrolled_1(enrolled_1), .enrolled_2(enrolled_2), .enrolled_3(enrolled_3),
        .close_poll(close_poll), .vote_valid(vote_valid), .vote_ready(b_ready),
        .vote_cred(vote_cred), .vote_cand(vote_cand), .resp_valid(b_rv),
        .resp_code(b_code), .tally_0(b_t[0]), .tally_1(b_t[1]), .tally_2(b_t[2]),
        .tally_3(b_t[3]), .voted_mask(b_mask), .enrolled(b_en), .closed(b_cl),
        .locked(b_lk)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // ------------------------------------------------------------------
    // Reference model: one record of the poll per instance.
    // ------------------------------------------------------------------
    logic [127:0] m_cred [2][3];
    bit           m_en [2];
    bit           m_closed;
    bit           m_locked [2];
    int           m_fails [2];
    bit           m_voted [2][3];
    int           m_tally [2][4];
    int           c_mf [2]   = '{MF_A, MF_B};
    int           c_cmax [2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};

    function automatic void m_reset();
        m_closed = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_en[i] = 1'b0;
            m_locked[i] = 1'b0;
            m_fails[i] = 0;
            for (int v = 0; v < 3; v++) begin
                m_voted[i][v] = 1'b0;
                m_cred[i][v] = '0;
            end
            for (int k = 0; k < 4; k++) m_tally[i][k] = 0;
        end
    endfunction

    function automatic void m_enroll(logic [127:0] c1, logic [127:0] c2, logic [127:0] c3);
        for (int i = 0; i < 2; i++) begin
            if (!m_en[i]) begin
                m_cred[i][0] = c1;
                m_cred[i][1] = c2;
                m_cred[i][2] = c3;
                m_en[i] = 1'b1;
            end
        end
    endfunction

    function automatic logic [1:0] m_vote(int i, logic [127:0] c, logic [1:0] k);
        int who = -1;
        if (m_closed || m_locked[i]) return 2'b11;
        for (int v = 2; v >= 0; v--) if (m_cred[i][v] == c) who = v;
        if (who < 0) begin
            m_fails[i]++;
            if (m_fails[i] >= c_mf[i]) m_locked[i] = 1'b1;
            return 2'b01;
        end
        if (m_voted[i][who]) return 2'b10;
        m_voted[i][who] = 1'b1;
        if (m_tally[i][k] < c_cmax[i]) m_tally[i][k]++;
        return 2'b00;
    endfunction

    function automatic logic [2:0] m_mask(int i);
        return {m_voted[i][2], m_voted[i][1], m_voted[i][0]};
    endfunction

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string tag);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("%s_a_tally%0d", tag, j), 32'(a_t[j]), 32'(m_tally[0][j]));
            chk($sformatf("%s_b_tally%0d", tag, j), 32'(b_t[j]), 32'(m_tally[1][j]));
        end
        chk({tag, "_a_mask"}, 32'(a_mask), 32'(m_mask(0)));
        chk({tag, "_b_mask"}, 32'(b_mask), 32'(m_mask(1)));
        chk({tag, "_a_locked"}, 32'(a_lk), 32'(m_locked[0]));
        chk({tag, "_b_locked"}, 32'(b_lk), 32'(m_locked[1]));
        chk({tag, "_a_closed"}, 32'(a_cl), 32'(m_closed));
        chk({tag, "_b_closed"}, 32'(b_cl), 32'(m_closed));
        chk({tag, "_a_enrolled"}, 32'(a_en), 32'(m_en[0]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vote_valid = 1'b0;
        enroll_load = 1'b0;
        close_poll = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    task automatic do_enroll(input logic [127:0] c1, input logic [127:0] c2, input logic [127:0] c3);
        enrolled_1 = c1;
        enrolled_2 = c2;
        enrolled_3 = c3;
        enroll_load = 1'b1;
        @(negedge clk);
        enroll_load = 1'b0;
        m_enroll(c1, c2, c3);
    endtask

    task automatic pulse_close();
        close_poll = 1'b1;
        @(negedge clk);
        close_poll = 1'b0;
        m_closed = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!a_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_wait"}, 32'(a_ready), 32'd1);
    endtask

    // Full ballot with cycle-exact checks; called at a negedge while idle.
    task automatic run_ballot(input string tag, input logic [127:0] c, input logic [1:0] k,
                              output logic [1:0] ca, output logic [1:0] cb);
        logic [1:0] ea, eb;
        wait_ready(tag);
        vote_valid = 1'b1;
        vote_cred = c;
        vote_cand = k;
        ea = m_vote(0, c, k);
        eb = m_vote(1, c, k);
        @(negedge clk);                                       // T+1
        vote_valid = 1'b0;
        chk({tag, "_t1_ready"}, 32'(a_ready), 32'd0);
        chk({tag, "_t1_rv"}, 32'(a_rv), 32'd0);
        @(negedge clk);                                       // T+2
        chk({tag, "_t2_ready"}, 32'(a_ready), 32'd0);
        chk({tag, "_t2_rv"}, 32'(a_rv), 32'd0);
        @(negedge clk);                                       // T+3
        chk({tag, "_t3_a_rv"}, 32'(a_rv), 32'd1);
        chk({tag, "_t3_b_rv"}, 32'(b_rv), 32'd1);
        chk({tag, "_t3_ready"}, 32'(a_ready), 32'd0);
        chk({tag, "_a_code"}, 32'(a_code), 32'(ea));
        chk({tag, "_b_code"}, 32'(b_code), 32'(eb));
        chk_state(tag);
        ca = a_code;
        cb = b_code;
        @(negedge clk);                                       // T+4
        chk({tag, "_t4_ready"}, 32'(a_ready), 32'd1);
        chk({tag, "_t4_rv"}, 32'(a_rv), 32'd0);
        chk({tag, "_t4_hold_code"}, 32'(a_code), 32'(ea));
    endtask

    typedef struct {
        int         sel;
        logic [1:0] cand;
        logic [1:0] code_a;
        logic [1:0] code_b;
        int         tal_a;
        int         tal_b;
        bit         lk_a;
        bit         lk_b;
    } vec_t;

    logic [127:0] cr [4];
    vec_t         tbl [8];

    initial begin
        logic [1:0] ca, cb;
        logic [127:0] d, e, f, r1, r2, r3, rc;
        int n;

        cr[0] = 128'hA5A5_0000_1111_2222_3333_4444_5555_0001;
        cr[1] = 128'hB6B6_0000_1111_2222_3333_4444_5555_0002;
        cr[2] = 128'hC7C7_0000_1111_2222_3333_4444_5555_0003;
        cr[3] = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0099;
        //          sel cand  codeA  codeB  tallyA tallyB lockA lockB
        tbl[0] = '{0, 2'd2, 2'b00, 2'b00, 1, 1, 1'b0, 1'b0};
        tbl[1] = '{0, 2'd1, 2'b10, 2'b10, 0, 0, 1'b0, 1'b0};
        tbl[2] = '{1, 2'd0, 2'b00, 2'b00, 1, 1, 1'b0, 1'b0};
        tbl[3] = '{2, 2'd0, 2'b00, 2'b00, 2, 1, 1'b0, 1'b0};
        tbl[4] = '{3, 2'd3, 2'b01, 2'b01, 0, 0, 1'b0, 1'b1};
        tbl[5] = '{3, 2'd3, 2'b01, 2'b11, 0, 0, 1'b0, 1'b1};
        tbl[6] = '{3, 2'd3, 2'b01, 2'b11, 0, 0, 1'b1, 1'b1};
        tbl[7] = '{1, 2'd0, 2'b11, 2'b11, 2, 1, 1'b1, 1'b1};

        // Reset values.
        m_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_a_rv", 32'(a_rv), 32'd0);
        chk("rst_b_rv", 32'(b_rv), 32'd0);
        chk("rst_a_code", 32'(a_code), 32'd0);
        chk_state("rst");
        rst = 1'b0;

        // Enrollment, then the directed table.
        do_enroll(cr[0], cr[1], cr[2]);
        chk("enr_a_enrolled", 32'(a_en), 32'd1);
        chk("enr_a_ready", 32'(a_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            run_ballot($sformatf("tbl%0d", i), cr[tbl[i].sel], tbl[i].cand, ca, cb);
            chk($sformatf("tbl%0d_codeA", i), 32'(ca), 32'(tbl[i].code_a));
            chk($sformatf("tbl%0d_codeB", i), 32'(cb), 32'(tbl[i].code_b));
            chk($sformatf("tbl%0d_tallyA", i), 32'(a_t[tbl[i].cand]), 32'(tbl[i].tal_a));
            chk($sformatf("tbl%0d_tallyB", i), 32'(b_t[tbl[i].cand]), 32'(tbl[i].tal_b));
            chk($sformatf("tbl%0d_lockA", i), 32'(a_lk), 32'(tbl[i].lk_a));
            chk($sformatf("tbl%0d_lockB", i), 32'(b_lk), 32'(tbl[i].lk_b));
        end

        // Closed poll rejects a valid voter.
        do_reset();
        do_enroll(cr[0], cr[1], cr[2]);
        pulse_close();
        chk("close_flag", 32'(a_cl), 32'd1);
        run_ballot("closed_c3", cr[2], 2'd3, ca, cb);
        chk("closed_c3_code", 32'(ca), 32'b11);
        chk("closed_c3_mask", 32'(a_mask), 32'd0);

        // Reset during COMMIT discards the ballot.
        do_reset();
        do_enroll(cr[0], cr[1], cr[2]);
        run_ballot("pre_rst", cr[0], 2'd0, ca, cb);
        wait_ready("rstc");
        vote_valid = 1'b1;
        vote_cred = cr[1];
        vote_cand = 2'd1;
        @(negedge clk);                       // CHECK
        vote_valid = 1'b0;
        @(negedge clk);                       // COMMIT
        rst = 1'b1;
        @(negedge clk);
        m_reset();
        chk("rstc_rv", 32'(a_rv), 32'd0);
        chk("rstc_ready", 32'(a_ready), 32'd0);
        chk("rstc_code", 32'(a_code), 32'd0);
        chk_state("rstc");
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (a_rv || b_rv) n++;
        end
        chk("rstc_no_resp", 32'(n), 32'd0);

        // Re-enroll with new credentials; old ones are now unknown.
        d = 128'h0D0D_0D0D_0D0D_0D0D_0D0D_0D0D_0D0D_0D0D;
        e = 128'h0E0E_0E0E_0E0E_0E0E_0E0E_0E0E_0E0E_0E0E;
        f = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
        do_enroll(d, e, f);
        run_ballot("reen_old", cr[0], 2'd0, ca, cb);
        chk("reen_old_code", 32'(ca), 32'b01);
        run_ballot("reen_d", d, 2'd1, ca, cb);
        chk("reen_d_code", 32'(ca), 32'b00);
        do_enroll(cr[3], cr[3], cr[3]);       // must be ignored
        run_ballot("frozen_e", e, 2'd2, ca, cb);
        chk("frozen_e_code", 32'(ca), 32'b00);

        // close_poll during CHECK does not affect the ballot in flight.
        wait_ready("cchk");
        vote_valid = 1'b1;
        vote_cred = f;
        vote_cand = 2'd3;
        ca = m_vote(0, f, 2'd3);
        cb = m_vote(1, f, 2'd3);
        @(negedge clk);                       // CHECK
        vote_valid = 1'b0;
        close_poll = 1'b1;
        @(negedge clk);                       // COMMIT
        close_poll = 1'b0;
        m_closed = 1'b1;
        @(negedge clk);                       // RESP
        chk("cchk_rv", 32'(a_rv), 32'd1);
        chk("cchk_code", 32'(a_code), 32'b00);
        chk("cchk_model_code", 32'(a_code), 32'(ca));
        chk_state("cchk");
        @(negedge clk);
        run_ballot("after_close", f, 2'd3, ca, cb);
        chk("after_close_code", 32'(ca), 32'b11);

        // Randomized rounds against the model.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            r1 = {$urandom, $urandom, $urandom, $urandom};
            r2 = ($urandom_range(0, 3) == 0) ? r1 : {$urandom, $urandom, $urandom, $urandom};
            r3 = ($urandom_range(0, 4) == 0) ? r2 : {$urandom, $urandom, $urandom, $urandom};
            do_enroll(r1, r2, r3);
            for (int b = 0; b < 12; b++) begin
                case ($urandom_range(0, 4))
                    0:       rc = r1;
                    1:       rc = r2;
                    2:       rc = r3;
                    default: rc = {$urandom, $urandom, $urandom, $urandom};
                endcase
                if ($urandom_range(0, 19) == 0) pulse_close();
                run_ballot($sformatf("rnd%0d_%0d", r, b), rc, 2'($urandom_range(0, 3)), ca, cb);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
